// File: rtl/fifo_pkg.sv
// Shared defaults and width helper for the programmable-threshold synchronous FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_SIZE  = 8;
    localparam int unsigned FIFO_DEPTH = 8;

    // Occupancy counter width: needs one extra bit to represent a full FIFO.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// DEPTH x SIZE register file: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned SIZE  = FIFO_SIZE,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    logic [SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem[raddr];
    end

endmodule : fifo_ram

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and registered read data.
// Optional sticky overflow/underflow flags with clr_err are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int unsigned SIZE     = FIFO_SIZE,
    parameter int unsigned DEPTH    = FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
`ifdef SYNC_FIFO_ERR_EN
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     underflow,
`endif
    input  logic                     valid_write,
    input  logic [SIZE-1:0]          data_in,
    input  logic                     read_en,
    output logic [SIZE-1:0]          data_out,
    output logic                     data_valid,
    output logic                     f_flag,
    output logic                     e_flag,
    output logic                     almost_full_flag,
    output logic                     almost_empty_flag,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    // Reject illegal configurations at elaboration.
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_prog: DEPTH must be a power of two >= 4");
    end
    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $error("sync_fifo_prog: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [SIZE-1:0] rd_data;
    logic            rd_acc_c;
    logic            wr_acc_c;

    // A full FIFO can still take a write when a read frees a slot on the same edge.
    always_comb begin
        rd_acc_c = read_en & ~e_flag;
        wr_acc_c = valid_write & (~f_flag | rd_acc_c);
    end

    fifo_ram #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_c),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc_c;
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc_c) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= rd_data;
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Status flags decode directly from the registered occupancy.
    always_comb begin
        f_flag            = (count == CW'(DEPTH));
        e_flag            = (count == '0);
        almost_full_flag  = (count >= CW'(AF_LEVEL));
        almost_empty_flag = (count <= CW'(AE_LEVEL));
    end

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags; a new error on the same edge wins over clr_err.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (valid_write && !wr_acc_c) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (read_en && !rd_acc_c) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule : sync_fifo_prog

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: queue-based reference model plus directed literal checks.
module tb_sync_fifo_prog;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFL   = 6;
    localparam int unsigned AEL   = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            n_rst;
    logic            valid_write;
    logic [SIZE-1:0] data_in;
    logic            read_en;
    logic            clr_err;
    logic [SIZE-1:0] data_out;
    logic            data_valid;
    logic            f_flag;
    logic            e_flag;
    logic            almost_full_flag;
    logic            almost_empty_flag;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            underflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int q[$];
    int exp_dout = 0;
    int exp_dv   = 0;
    int exp_ovf  = 0;
    int exp_udf  = 0;

    sync_fifo_prog #(
        .SIZE     (SIZE),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AFL),
        .AE_LEVEL (AEL)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
`ifdef SYNC_FIFO_ERR_EN
        .clr_err           (clr_err),
        .overflow          (overflow),
        .underflow         (underflow),
`endif
        .valid_write       (valid_write),
        .data_in           (data_in),
        .read_en           (read_en),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .f_flag            (f_flag),
        .e_flag            (e_flag),
        .almost_full_flag  (almost_full_flag),
        .almost_empty_flag (almost_empty_flag),
        .count             (count)
    );

`ifndef SYNC_FIFO_ERR_EN
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compare_all();
        int n;
        n = q.size();
        chk("count", int'(count), n);
        chk("f_flag", int'(f_flag), int'(n == DEPTH));
        chk("e_flag", int'(e_flag), int'(n == 0));
        chk("almost_full", int'(almost_full_flag), int'(n >= AFL));
        chk("almost_empty", int'(almost_empty_flag), int'(n <= AEL));
        chk("data_out", int'(data_out), exp_dout);
        chk("data_valid", int'(data_valid), exp_dv);
`ifdef SYNC_FIFO_ERR_EN
        chk("overflow", int'(overflow), exp_ovf);
        chk("underflow", int'(underflow), exp_udf);
`endif
    endtask

    // Apply one cycle of inputs, advance the model at the edge, then check.
    task automatic step(input bit w, input int d, input bit r, input bit clr);
        bit rd_ok;
        bit wr_ok;
        valid_write = w;
        data_in     = SIZE'(d);
        read_en     = r;
        clr_err     = clr;
        @(posedge clk);
        rd_ok = r && (q.size() != 0);
        wr_ok = w && ((q.size() != DEPTH) || rd_ok);
        exp_dv = int'(rd_ok);
        if (rd_ok) exp_dout = q.pop_front();
        if (wr_ok) q.push_back(d & 8'hff);
        if (w && !wr_ok) exp_ovf = 1;
        else if (clr)    exp_ovf = 0;
        if (r && !rd_ok) exp_udf = 1;
        else if (clr)    exp_udf = 0;
        #1;
        compare_all();
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = 0;
        exp_dv   = 0;
        exp_ovf  = 0;
        exp_udf  = 0;
    endtask

    initial begin
        int d;
        int wp;
        int rp;
        valid_write = 1'b0;
        data_in     = '0;
        read_en     = 1'b0;
        clr_err     = 1'b0;
        n_rst       = 1'b0;
        model_reset();

        // Reset state
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_e_flag", int'(e_flag), 1);
        chk("rst_ae_flag", int'(almost_empty_flag), 1);
        chk("rst_f_flag", int'(f_flag), 0);
        chk("rst_af_flag", int'(almost_full_flag), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Fill with 10..17
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 10 + i, 1'b0, 1'b0);
            chk("fill_count", int'(count), i + 1);
            chk("fill_ae", int'(almost_empty_flag), int'(i + 1 <= 2));
            chk("fill_af", int'(almost_full_flag), int'(i + 1 >= 6));
        end
        chk("fill_full", int'(f_flag), 1);

        // Drain: 10..17 in order, one data_valid pulse each
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 1'b1, 1'b0);
            chk("drain_data", int'(data_out), 10 + i);
            chk("drain_valid", int'(data_valid), 1);
        end
        chk("drain_empty", int'(e_flag), 1);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("drain_valid_drop", int'(data_valid), 0);
        chk("drain_hold", int'(data_out), 17);

        // Full boundary: write with read while full
        for (int i = 0; i < 8; i++) step(1'b1, 10 + i, 1'b0, 1'b0);
        step(1'b1, 99, 1'b1, 1'b0);
        chk("full_rw_data", int'(data_out), 10);
        chk("full_rw_count", int'(count), 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 1'b1, 1'b0);
            chk("full_rw_drain", int'(data_out), (i == 7) ? 99 : 11 + i);
        end

        // Empty boundary: write with read while empty, no bypass
        step(1'b1, 5, 1'b1, 1'b0);
        chk("empty_rw_count", int'(count), 1);
        chk("empty_rw_valid", int'(data_valid), 0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("empty_rw_read", int'(data_out), 5);

        // Wrap: 3 writes / 2 reads with incrementing data
        d  = 0;
        rp = -1;
        for (int k = 0; k < 20; k++) begin
            if ((k % 5) < 3) begin
                step(1'b1, 40 + d, 1'b0, 1'b0);
                d++;
            end else begin
                step(1'b0, 0, 1'b1, 1'b0);
                if (data_valid) begin
                    chk("wrap_incr", int'(int'(data_out) > rp), 1);
                    rp = int'(data_out);
                end
            end
        end

`ifdef SYNC_FIFO_ERR_EN
        // Error flags: overflow on write when full, underflow on read when empty
        while (q.size() < DEPTH) step(1'b1, 60, 1'b0, 1'b0);
        step(1'b1, 77, 1'b0, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("ovf_clr", int'(overflow), 0);
        while (q.size() > 0) step(1'b0, 0, 1'b1, 1'b0);
        chk("ovf_mem_intact", int'(data_out), 60);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("udf_set", int'(underflow), 1);
        step(1'b0, 0, 1'b1, 1'b1);
        chk("udf_set_wins", int'(underflow), 1);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("udf_clr", int'(underflow), 0);
`endif

        // Randomized traffic with varying write/read bias
        for (int blk = 0; blk < 12; blk++) begin
            wp = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 20 : 50);
            rp = 100 - wp;
            for (int c = 0; c < 150; c++) begin
                step(bit'($urandom_range(0, 99) < wp), int'($urandom_range(0, 255)),
                     bit'($urandom_range(0, 99) < rp), bit'($urandom_range(0, 9) == 0));
            end
        end

        // Asynchronous reset mid-cycle with 5 entries stored
        while (q.size() > 5) step(1'b0, 0, 1'b1, 1'b0);
        while (q.size() < 5) step(1'b1, 33, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 34, 1'b0, 1'b0);
        chk("pre_rst_count", int'(count), 5);
        valid_write = 1'b0;
        read_en     = 1'b0;
        clr_err     = 1'b0;
        #3;
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_e_flag", int'(e_flag), 1);
        chk("async_rst_data_out", int'(data_out), 0);
        compare_all();
        #2;
        n_rst = 1'b1;
        step(1'b0, 0, 1'b1, 1'b0);
        chk("post_rst_no_data", int'(data_valid), 0);
        step(1'b1, 21, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("post_rst_read", int'(data_out), 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sync_fifo_prog
